fix_c_mult_stream: RTL and testbench
====================================

Name: fix_c_mult_stream

Overview:
- Multi-lane, fully pipelined fixed-point complex multiplier with a valid/ready stream interface.
- Supports per-beat conjugate mode, per-beat shift, selectable rounding, and saturation with per-beat and sticky overflow reporting.
- Sits between stream-based FFT/correlator stages and replaces ad-hoc combinational complex multiplies wherever backpressure must be honoured.

Parameters:
- N_LANES, 1, number of independent complex lanes; all lanes share one handshake.
- IN_WIDTH, 16, signed two's-complement width of each real/imag input component.
- OUT_WIDTH, 16, signed width of each output component after shift and saturation.
- ROUND_MODE, 1, 0 = truncate (floor), 1 = round-half-up before shift.
- SAT_EN, 1, 1 = saturate to OUT_WIDTH; 0 = wrap (keep LSBs), sat flags forced 0.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- opa_R  input  N_LANES*IN_WIDTH  operand A real, lane k at bits [k*IN_WIDTH +: IN_WIDTH].
- opa_I  input  N_LANES*IN_WIDTH  operand A imag.
- opb_R  input  N_LANES*IN_WIDTH  operand B real.
- opb_I  input  N_LANES*IN_WIDTH  operand B imag.
- conj  input  N_LANES  per-lane: 1 = A*conj(B), 0 = A*B.
- shift_amount  input  $clog2(2*IN_WIDTH+2)  right shift applied to the full-precision sums; applies to all lanes of the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_R  output  N_LANES*OUT_WIDTH  result real.
- out_I  output  N_LANES*OUT_WIDTH  result imag.
- sat_flag  output  N_LANES  per-lane: R or I saturated on this output beat.
- clr_ovf  input  1  clears ovf_sticky.
- ovf_sticky  output  1  set on any saturation of any accepted beat.

Behaviour:
- Reset: in_valid captured as 0 in all stages. out_valid=0, out_R=out_I=0, sat_flag=0, ovf_sticky=0. in_ready=1 on the first cycle after rst deasserts.
- Reset mid-operation: all in-flight beats are discarded. The cycle after rst is sampled high, out_valid=0.
- Pipeline: 3 registered stages, no combinational path from inputs to outputs.
  - S1: register operands, conj and shift.
  - S2: four signed products, 2*IN_WIDTH bits each.
  - S3: add/sub, round, shift, saturate into the output registers.
- Latency: a beat accepted at cycle t appears with out_valid=1 at cycle t+3 when no stall occurs.
- Stall rule: en = !(out_valid && !out_ready). All stages advance only when en=1. in_ready = en.
- Under stall, outputs hold stable, valid-stage bubbles are preserved, and no beat is dropped or duplicated. Order is strictly preserved.
- Arithmetic at 2*IN_WIDTH+2 bits:
  - conj=0: R = aR*bR - aI*bI, I = aR*bI + aI*bR.
  - conj=1: R = aR*bR + aI*bI, I = aI*bR - aR*bI.
- Rounding: if ROUND_MODE=1 and s>0, add 2^(s-1) before an arithmetic shift right by s. Otherwise apply a plain arithmetic shift.
- shift_amount values above 2*IN_WIDTH+1 are clamped to 2*IN_WIDTH+1.
- Saturation: a shifted value outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps to the nearest bound, and sat_flag[k] is set for that beat.
- sat_flag is registered alongside out_R/out_I and is valid only with out_valid.
- ovf_sticky: set when an S3 result saturates and en=1. Cleared by clr_ovf. If a set and clr_ovf occur in the same cycle, set wins.
- A beat with in_valid=0 never affects ovf_sticky.

Decomposition:
- Package fix_pkg holds:
  - round_mode_e (TRUNC, RND_HALF_UP);
  - function fix_sat(value, out_width) returning the clamped value and a flag;
  - localparam helpers for product width (2*IN_WIDTH) and sum width (2*IN_WIDTH+2).
- Sub-module fix_c_mult_lane: one lane's S1-S3 datapath with an en input. The top level instantiates N_LANES copies and owns the valid pipeline, the handshake and ovf_sticky.

Test Plan:
- N_LANES=1, W=16, shift 0, conj 0: A=(1,2), B=(3,4) -> out=(-5,10) exactly 3 cycles after acceptance, sat_flag=0.
- Same operands with conj=1 -> out=(11,2).
- A=B=(-32768,-32768), conj 0, shift 0 -> R=0, I=32767, sat_flag=1, ovf_sticky=1. Pulse clr_ovf in the same cycle as a new saturating beat -> ovf_sticky stays 1.
- ROUND_MODE=1, shift 1: A=(3,0), B=(1,0) -> R=2; A=(-3,0) -> R=-1. With ROUND_MODE=0 -> R=1 and R=-2.
- Stream 16 back-to-back random beats, N_LANES=4, with out_ready toggling pseudo-randomly -> outputs match the golden model in order, with no drops or duplicates, and outputs hold stable while out_valid && !out_ready.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, none of the 3 beats ever emerges, and the first post-reset beat appears 3 cycles after acceptance.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared types and helpers for the fixed-point complex multiplier: rounding
// mode encoding, internal width helpers and the saturating clamp.
package fix_pkg;

    typedef enum logic {
        TRUNC       = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    // Widest value the clamp helper can take; covers IN_WIDTH up to 31.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] value;
        logic                        sat;
    } sat_result_t;

    function automatic int prod_width(input int in_width);
        return 2 * in_width;
    endfunction

    function automatic int sum_width(input int in_width);
        return 2 * in_width + 2;
    endfunction

    function automatic sat_result_t fix_sat(input logic signed [SAT_MAX_W-1:0] value,
                                            input int out_width);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_result_t                 res;
        hi        = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo        = -(64'sd1 <<< (out_width - 1));
        res.value = value;
        res.sat   = 1'b0;
        if (value > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (value < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fix_c_mult_lane.sv
// One complex-multiply lane: operand register, four products, then
// add/sub, round, shift and saturate into the output registers.
module fix_c_mult_lane
    import fix_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int ROUND_MODE = 1,
    parameter int SAT_EN     = 1,
    parameter int SHW        = $clog2(2 * IN_WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  a_r,
    input  logic [IN_WIDTH-1:0]  a_i,
    input  logic [IN_WIDTH-1:0]  b_r,
    input  logic [IN_WIDTH-1:0]  b_i,
    input  logic                 conj,
    input  logic [SHW-1:0]       shift_amount,
    output logic [OUT_WIDTH-1:0] out_r,
    output logic [OUT_WIDTH-1:0] out_i,
    output logic                 sat_flag,
    output logic                 sat_next
);
    localparam int              PW        = prod_width(IN_WIDTH);
    localparam int              SW        = sum_width(IN_WIDTH);
    localparam logic [SHW-1:0]  MAX_SHIFT = SHW'(SW - 1);
    localparam logic [SHW-1:0]  ONE_SHIFT = SHW'(1);
    localparam logic [SW-1:0]   ONE_SUM   = SW'(1);

    logic signed [IN_WIDTH-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic                       s1_conj;
    logic [SHW-1:0]             s1_shift;
    logic signed [PW-1:0]       s2_rr, s2_ii, s2_ri, s2_ir;
    logic                       s2_conj;
    logic [SHW-1:0]             s2_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
            s1_conj  <= 1'b0;
            s1_shift <= '0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
            s2_conj  <= 1'b0;
            s2_shift <= '0;
        end else if (en) begin
            s1_ar    <= a_r;
            s1_ai    <= a_i;
            s1_br    <= b_r;
            s1_bi    <= b_i;
            s1_conj  <= conj;
            s1_shift <= (shift_amount > MAX_SHIFT) ? MAX_SHIFT : shift_amount;
            s2_rr    <= PW'(s1_ar) * PW'(s1_br);
            s2_ii    <= PW'(s1_ai) * PW'(s1_bi);
            s2_ri    <= PW'(s1_ar) * PW'(s1_bi);
            s2_ir    <= PW'(s1_ai) * PW'(s1_br);
            s2_conj  <= s1_conj;
            s2_shift <= s1_shift;
        end
    end

    logic signed [SW-1:0]        e_rr, e_ii, e_ri, e_ir;
    logic signed [SW-1:0]        sum_r, sum_i, bias, shf_r, shf_i;
    logic signed [SAT_MAX_W-1:0] wide_r, wide_i;
    sat_result_t                 clamp_r, clamp_i;
    logic [OUT_WIDTH-1:0]        res_r, res_i;
    logic                        flag_r, flag_i;

    always_comb begin
        e_rr    = SW'(s2_rr);
        e_ii    = SW'(s2_ii);
        e_ri    = SW'(s2_ri);
        e_ir    = SW'(s2_ir);
        sum_r   = e_rr - e_ii;
        sum_i   = e_ri + e_ir;
        bias    = '0;
        res_r   = '0;
        res_i   = '0;
        flag_r  = 1'b0;
        flag_i  = 1'b0;
        if (s2_conj) begin
            sum_r = e_rr + e_ii;
            sum_i = e_ir - e_ri;
        end
        // Half-up bias sits just below the bit that becomes the new LSB.
        if (ROUND_MODE == int'(RND_HALF_UP) && s2_shift != '0) begin
            bias = ONE_SUM << (s2_shift - ONE_SHIFT);
        end
        shf_r   = (sum_r + bias) >>> s2_shift;
        shf_i   = (sum_i + bias) >>> s2_shift;
        wide_r  = SAT_MAX_W'(shf_r);
        wide_i  = SAT_MAX_W'(shf_i);
        clamp_r = fix_sat(wide_r, OUT_WIDTH);
        clamp_i = fix_sat(wide_i, OUT_WIDTH);
        if (SAT_EN != 0) begin
            res_r  = OUT_WIDTH'(clamp_r.value);
            res_i  = OUT_WIDTH'(clamp_i.value);
            flag_r = clamp_r.sat;
            flag_i = clamp_i.sat;
        end else begin
            res_r = OUT_WIDTH'(shf_r);
            res_i = OUT_WIDTH'(shf_i);
        end
    end

    assign sat_next = flag_r | flag_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r    <= '0;
            out_i    <= '0;
            sat_flag <= 1'b0;
        end else if (en) begin
            out_r    <= res_r;
            out_i    <= res_i;
            sat_flag <= sat_next;
        end
    end

endmodule

// File: rtl/fix_c_mult_stream.sv
// Multi-lane pipelined fixed-point complex multiplier with a valid/ready
// stream interface, shared handshake and sticky overflow reporting.
module fix_c_mult_stream
    import fix_pkg::*;
#(
    parameter int N_LANES    = 1,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int ROUND_MODE = 1,
    parameter int SAT_EN     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_LANES*IN_WIDTH-1:0]    opa_R,
    input  logic [N_LANES*IN_WIDTH-1:0]    opa_I,
    input  logic [N_LANES*IN_WIDTH-1:0]    opb_R,
    input  logic [N_LANES*IN_WIDTH-1:0]    opb_I,
    input  logic [N_LANES-1:0]             conj,
    input  logic [$clog2(2*IN_WIDTH+2)-1:0] shift_amount,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_LANES*OUT_WIDTH-1:0]   out_R,
    output logic [N_LANES*OUT_WIDTH-1:0]   out_I,
    output logic [N_LANES-1:0]             sat_flag,
    input  logic                           clr_ovf,
    output logic                           ovf_sticky
);
    localparam int SHW = $clog2(2 * IN_WIDTH + 2);

    // Handshake: a beat transfers on any edge where valid && ready. The whole
    // pipeline advances only while the output register is empty or being
    // drained, so in_ready never depends on in_valid.
    logic                en;
    logic                v1, v2;
    logic [N_LANES-1:0]  sat_next;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    // Bubbles carry garbage data, so only a valid beat may set the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (en && v2 && |sat_next) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        fix_c_mult_lane #(
            .IN_WIDTH   (IN_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH),
            .ROUND_MODE (ROUND_MODE),
            .SAT_EN     (SAT_EN),
            .SHW        (SHW)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .a_r          (opa_R[k*IN_WIDTH +: IN_WIDTH]),
            .a_i          (opa_I[k*IN_WIDTH +: IN_WIDTH]),
            .b_r          (opb_R[k*IN_WIDTH +: IN_WIDTH]),
            .b_i          (opb_I[k*IN_WIDTH +: IN_WIDTH]),
            .conj         (conj[k]),
            .shift_amount (shift_amount),
            .out_r        (out_R[k*OUT_WIDTH +: OUT_WIDTH]),
            .out_i        (out_I[k*OUT_WIDTH +: OUT_WIDTH]),
            .sat_flag     (sat_flag[k]),
            .sat_next     (sat_next[k])
        );
    end

endmodule

// File: tb/tb_fix_c_mult_stream.sv
// Self-checking bench: a 4-lane rounding instance plus a 1-lane truncating
// instance sharing stimulus, checked against an arithmetic reference model.
module tb_fix_c_mult_stream;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int OW  = 16;
    localparam int SHW = 6;
    localparam int EW  = 2 * N * OW + N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic clr_ovf = 1'b0;
    logic [N*W-1:0] opa_R = '0, opa_I = '0, opb_R = '0, opb_I = '0;
    logic [N-1:0]   conj = '0;
    logic [SHW-1:0] shift_amount = '0;

    logic           in_ready, out_valid, ovf_sticky;
    logic [N*OW-1:0] out_R, out_I;
    logic [N-1:0]   sat_flag;

    logic           t_in_ready, t_out_valid, t_sat_flag, t_ovf_sticky;
    logic [OW-1:0]  t_out_R, t_out_I;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    fix_c_mult_stream #(
        .N_LANES(N), .IN_WIDTH(W), .OUT_WIDTH(OW), .ROUND_MODE(1), .SAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa_R(opa_R), .opa_I(opa_I), .opb_R(opb_R), .opb_I(opb_I),
        .conj(conj), .shift_amount(shift_amount),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_I(out_I), .sat_flag(sat_flag),
        .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky)
    );

    fix_c_mult_stream #(
        .N_LANES(1), .IN_WIDTH(W), .OUT_WIDTH(OW), .ROUND_MODE(0), .SAT_EN(1)
    ) dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .opa_R(opa_R[W-1:0]), .opa_I(opa_I[W-1:0]), .opb_R(opb_R[W-1:0]), .opb_I(opb_I[W-1:0]),
        .conj(conj[0:0]), .shift_amount(shift_amount),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_R(t_out_R), .out_I(t_out_I), .sat_flag(t_sat_flag),
        .clr_ovf(clr_ovf), .ovf_sticky(t_ovf_sticky)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: exact integer complex product, round, shift, clamp.
    function automatic void model_lane(input logic signed [W-1:0] ar, ai, br, bi,
                                       input logic cj, input int sh, input bit rnd,
                                       output logic [OW-1:0] r, output logic [OW-1:0] i,
                                       output logic sat);
        longint lar, lai, lbr, lbi, xr, xi, hi, lo;
        int s;
        lar = ar; lai = ai; lbr = br; lbi = bi;
        s = (sh > 2 * W + 1) ? 2 * W + 1 : sh;
        if (cj) begin
            xr = lar * lbr + lai * lbi;
            xi = lai * lbr - lar * lbi;
        end else begin
            xr = lar * lbr - lai * lbi;
            xi = lar * lbi + lai * lbr;
        end
        if (rnd && s > 0) begin
            xr = xr + (longint'(1) << (s - 1));
            xi = xi + (longint'(1) << (s - 1));
        end
        xr = xr >>> s;
        xi = xi >>> s;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        sat = 1'b0;
        if (xr > hi) begin xr = hi; sat = 1'b1; end
        else if (xr < lo) begin xr = lo; sat = 1'b1; end
        if (xi > hi) begin xi = hi; sat = 1'b1; end
        else if (xi < lo) begin xi = lo; sat = 1'b1; end
        r = xr[OW-1:0];
        i = xi[OW-1:0];
    endfunction

    // Driver: one beat on lane 0 (other lanes zero), out_ready held high.
    task automatic send_one(input logic [W-1:0] ar, ai, br, bi, input logic cj,
                            input logic [SHW-1:0] sh, input bit clr_at_out,
                            output int lat, output logic [OW-1:0] r, output logic [OW-1:0] i,
                            output logic s, output logic ovf, output logic [OW-1:0] tr);
        bit acc;
        int guard;
        int acc_cyc;
        @(posedge clk); #1;
        out_ready = 1'b1;
        opa_R = '0; opa_I = '0; opb_R = '0; opb_I = '0; conj = '0;
        opa_R[W-1:0] = ar; opa_I[W-1:0] = ai; opb_R[W-1:0] = br; opb_I[W-1:0] = bi;
        conj[0] = cj;
        shift_amount = sh;
        in_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            guard++;
            if (!acc) begin @(posedge clk); #1; end
        end while (!acc && guard < 50);
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; r = 'x; i = 'x; s = 1'bx; ovf = 1'bx; tr = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            clr_ovf = (clr_at_out && cyc == acc_cyc + 2);
            if (out_valid) begin
                lat = cyc - acc_cyc;
                r = out_R[OW-1:0];
                i = out_I[OW-1:0];
                s = sat_flag[0];
                ovf = ovf_sticky;
                tr = t_out_R;
                break;
            end
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_R !== '0) begin failures++; $display("FAIL reset_out_R got=%h exp=0", out_R); end
        checks++; if (out_I !== '0) begin failures++; $display("FAIL reset_out_I got=%h exp=0", out_I); end
        checks++; if (sat_flag !== '0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_ovf_sticky got=%b exp=0", ovf_sticky); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic;
        int lat; logic [OW-1:0] r, i, tr; logic s, ovf;
        send_one(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 6'd0, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (r !== 16'hFFFB) begin failures++; $display("FAIL basic_r got=%h exp=fffb", r); end
        checks++; if (i !== 16'd10) begin failures++; $display("FAIL basic_i got=%h exp=000a", i); end
        checks++; if (s !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", s); end
        send_one(16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 6'd0, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (r !== 16'd11) begin failures++; $display("FAIL conj_r got=%h exp=000b", r); end
        checks++; if (i !== 16'd2) begin failures++; $display("FAIL conj_i got=%h exp=0002", i); end
    endtask

    task automatic test_sat;
        int lat; logic [OW-1:0] r, i, tr; logic s, ovf;
        send_one(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 6'd0, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (r !== 16'd0) begin failures++; $display("FAIL sat_r got=%h exp=0000", r); end
        checks++; if (i !== 16'h7FFF) begin failures++; $display("FAIL sat_i got=%h exp=7fff", i); end
        checks++; if (s !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", s); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_sticky_set got=%b exp=1", ovf); end
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", ovf_sticky); end
        send_one(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 6'd0, 1'b1, lat, r, i, s, ovf, tr);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", ovf); end
    endtask

    task automatic test_round;
        int lat; logic [OW-1:0] r, i, tr; logic s, ovf;
        send_one(16'd3, 16'd0, 16'd1, 16'd0, 1'b0, 6'd1, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (r !== 16'd2) begin failures++; $display("FAIL round_pos got=%h exp=0002", r); end
        checks++; if (tr !== 16'd1) begin failures++; $display("FAIL trunc_pos got=%h exp=0001", tr); end
        send_one(16'hFFFD, 16'd0, 16'd1, 16'd0, 1'b0, 6'd1, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (r !== 16'hFFFF) begin failures++; $display("FAIL round_neg got=%h exp=ffff", r); end
        checks++; if (tr !== 16'hFFFE) begin failures++; $display("FAIL trunc_neg got=%h exp=fffe", tr); end
        // shift 63 clamps to 33
        send_one(16'hFFFF, 16'd0, 16'd1, 16'd0, 1'b0, 6'd63, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (r !== 16'd0) begin failures++; $display("FAIL clamp_round got=%h exp=0000", r); end
        checks++; if (tr !== 16'hFFFF) begin failures++; $display("FAIL clamp_trunc got=%h exp=ffff", tr); end
    endtask

    task automatic test_back_to_back;
        int got;
        bit done;
        bit prev_stall;
        logic [EW-1:0] saved, cur, e;
        exp_q.delete();
        got = 0; done = 0; prev_stall = 0; saved = '0;
        @(posedge clk); #1;
        fork
            begin
                for (int b = 0; b < 16; b++) begin
                    logic [W-1:0] ar, ai, br, bi;
                    logic [N*OW-1:0] er, ei;
                    logic [N-1:0] es;
                    logic [OW-1:0] r, i;
                    logic s;
                    bit acc;
                    int guard;
                    shift_amount = SHW'($urandom_range(0, 40));
                    for (int k = 0; k < N; k++) begin
                        ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
                        if ($urandom_range(0, 5) == 0) ar = {1'b1, {(W-1){1'b0}}};
                        if ($urandom_range(0, 5) == 0) bi = {1'b1, {(W-1){1'b0}}};
                        opa_R[k*W +: W] = ar; opa_I[k*W +: W] = ai;
                        opb_R[k*W +: W] = br; opb_I[k*W +: W] = bi;
                        conj[k] = 1'($urandom_range(0, 1));
                        model_lane(ar, ai, br, bi, conj[k], int'(shift_amount), 1'b1, r, i, s);
                        er[k*OW +: OW] = r; ei[k*OW +: OW] = i; es[k] = s;
                    end
                    exp_q.push_back({er, ei, es});
                    in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        guard++;
                        @(posedge clk); #1;
                    end while (!acc && guard < 100);
                end
                in_valid = 1'b0;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int c = 0; c < 800 && got < 16; c++) begin
                    @(negedge clk);
                    cur = {out_R, out_I, sat_flag};
                    if (prev_stall) begin
                        checks++;
                        if (cur !== saved || out_valid !== 1'b1) begin
                            failures++;
                            $display("FAIL stall_hold got=%h valid=%b exp=%h valid=1", cur, out_valid, saved);
                        end
                    end
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL stream_extra got=%h exp=none", cur);
                        end else begin
                            e = exp_q.pop_front();
                            if (cur !== e) begin
                                failures++;
                                $display("FAIL stream_beat%0d got=%h exp=%h", got, cur, e);
                            end
                        end
                        got++;
                    end
                    prev_stall = out_valid && !out_ready;
                    saved = cur;
                end
                done = 1;
            end
        join
        checks++; if (got !== 16 || exp_q.size() != 0) begin failures++; $display("FAIL stream_count got=%0d left=%0d exp=16 left=0", got, exp_q.size()); end
        got = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        checks++; if (got !== 0) begin failures++; $display("FAIL stream_dup got=%0d exp=0", got); end
    endtask

    task automatic test_reset_mid;
        int lat, ghosts; logic [OW-1:0] r, i, tr; logic s, ovf;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            opa_R = {$urandom, $urandom}; opa_I = {$urandom, $urandom};
            opb_R = {$urandom, $urandom}; opb_I = {$urandom, $urandom};
            conj = N'($urandom); shift_amount = SHW'($urandom_range(0, 20));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL midrst_sticky got=%b exp=0", ovf_sticky); end
        ghosts = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        checks++; if (ghosts !== 0) begin failures++; $display("FAIL midrst_ghost got=%0d exp=0", ghosts); end
        send_one(16'd5, 16'hFFF9, 16'd2, 16'd3, 1'b1, 6'd0, 1'b0, lat, r, i, s, ovf, tr);
        checks++; if (lat !== 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
        checks++; if (r !== 16'hFFF5) begin failures++; $display("FAIL midrst_r got=%h exp=fff5", r); end
        checks++; if (i !== 16'hFFE3) begin failures++; $display("FAIL midrst_i got=%h exp=ffe3", i); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_round();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
